// File: rtl/mem_pkg.sv
// mem_pkg: opcode/func3 constants and FSM state encoding shared by the memory request unit
package mem_pkg;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] FNC_LB    = 3'b000;
    localparam logic [2:0] FNC_LH    = 3'b001;
    localparam logic [2:0] FNC_LW    = 3'b010;
    localparam logic [2:0] FNC_LBU   = 3'b100;
    localparam logic [2:0] FNC_LHU   = 3'b101;
    localparam logic [2:0] FNC_SB    = 3'b000;
    localparam logic [2:0] FNC_SH    = 3'b001;
    localparam logic [2:0] FNC_SW    = 3'b010;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
endpackage

// File: rtl/mem_req_unit_if.sv
// mem_req_unit_if: data-memory request/response bus between the unit (master) and memory (slave)
interface mem_req_unit_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic [3:0]        mem_req_wmask;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    modport master (output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata,
                    input  mem_req_ready, mem_resp_valid, mem_resp_data);
    modport slave  (input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata,
                    output mem_req_ready, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/mem_req_unit_store_align.sv
// store_align: places store bytes/halves onto the 32-bit lanes and builds the byte write mask
module store_align
    import mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata
);
    always_comb begin
        wmask = func3 == FNC_SB ? 4'b0001 << addr :
                func3 == FNC_SH ? 4'b0011 << {addr[1], 1'b0} :
                func3 == FNC_SW ? 4'b1111 : 4'b0000;
        wdata = func3 == FNC_SB ? {4{data[7:0]}} :
                func3 == FNC_SH ? {2{data[15:0]}} : data;
    end
endmodule

// File: rtl/mem_req_unit.sv
// mem_req_unit: M-stage load/store sequencer issuing one memory request per access and stalling the pipe
module mem_req_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid_M,
    input  logic [6:0]        instr_op_M,
    input  logic [2:0]        instr_func3_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [DATA_W-1:0] store_data_M,
    output logic              stall_M,
    output logic              misalign_M,
    mem_req_unit_if.master    mem,
    output logic [DATA_W-1:0] DMEM_out,
    output logic [1:0]        load_addr_lo,
    output logic [2:0]        load_func3,
    output logic              load_done
);
    state_t            state, next;
    logic              access, misal, start, c_st;
    logic [2:0]        c_f3;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [3:0]        sa_mask;
    always_comb begin
        access = state == IDLE && instr_valid_M && (instr_op_M == OPC_LOAD || instr_op_M == OPC_STORE);
        misal  = instr_func3_M[1:0] == 2'b01 ? addr_M[0] :
                 instr_func3_M[1:0] == 2'b10 ? |addr_M[1:0] : 1'b0;
        start  = access && !misal;
        misalign_M = access && misal;
        stall_M    = start || state == REQ || state == RESP;
        next = state;
        case (state)
            IDLE:    next = start ? REQ : IDLE;
            REQ:     next = mem.mem_req_ready ? (c_st ? DONE : RESP) : REQ;
            RESP:    next = mem.mem_resp_valid ? DONE : RESP;
            default: next = IDLE;
        endcase
    end
    store_align u_align (
        .func3 (c_f3),
        .addr  (c_addr[1:0]),
        .data  (c_data),
        .wmask (sa_mask),
        .wdata (mem.mem_req_wdata)
    );
    assign mem.mem_req_valid = state == REQ;
    assign mem.mem_req_addr  = {c_addr[ADDR_W-1:2], 2'b00};
    assign mem.mem_req_we    = c_st;
    assign mem.mem_req_wmask = c_st ? sa_mask : 4'b0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            c_st         <= 1'b0;
            c_f3         <= '0;
            c_addr       <= '0;
            c_data       <= '0;
            DMEM_out     <= '0;
            load_addr_lo <= '0;
            load_func3   <= '0;
            load_done    <= 1'b0;
        end else begin
            state     <= next;
            load_done <= state == RESP && mem.mem_resp_valid;
            if (start) begin
                c_st   <= instr_op_M == OPC_STORE;
                c_f3   <= instr_func3_M;
                c_addr <= addr_M;
                c_data <= store_data_M;
            end
            // response data only counts while a load is actually waiting for it
            if (state == RESP && mem.mem_resp_valid) begin
                DMEM_out     <= mem.mem_resp_data;
                load_addr_lo <= c_addr[1:0];
                load_func3   <= c_f3;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_unit.sv
// tb_mem_req_unit: directed checks of stores, loads, misalignment, reset abandonment and back-to-back access
module tb_mem_req_unit;
    import mem_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;
    logic        stall, misalign, load_done;
    logic [31:0] dmem_out;
    logic [1:0]  lo;
    logic [2:0]  lf3;
    int          checks = 0;
    int          errors = 0;
    int          n_req = 0;
    mem_req_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    mem_req_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_M (iv),
        .instr_op_M    (op),
        .instr_func3_M (f3),
        .addr_M        (addr),
        .store_data_M  (sdata),
        .stall_M       (stall),
        .misalign_M    (misalign),
        .mem           (bus.master),
        .DMEM_out      (dmem_out),
        .load_addr_lo  (lo),
        .load_func3    (lf3),
        .load_done     (load_done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.mem_req_valid && bus.mem_req_ready) n_req++;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        iv = v; op = o; f3 = f; addr = a; sdata = d;
        #1;
    endtask
    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        tick; tick;
        chk("rst_stall", stall, 0);
        chk("rst_valid", bus.mem_req_valid, 0);
        chk("rst_dmem", dmem_out, 0);
        chk("rst_done", load_done, 0);
        chk("rst_lo", lo, 0);
        chk("rst_f3", lf3, 0);
        rst_n = 1'b1;
        // SB at byte 3, ready immediately
        bus.mem_req_ready = 1'b1;
        drive(1, OPC_STORE, FNC_SB, 32'h1003, 32'hAABBCCDD);
        chk("sb_start_stall", stall, 1);
        chk("sb_start_valid", bus.mem_req_valid, 0);
        tick;
        chk("sb_valid", bus.mem_req_valid, 1);
        chk("sb_addr", bus.mem_req_addr, 32'h1000);
        chk("sb_we", bus.mem_req_we, 1);
        chk("sb_wmask", bus.mem_req_wmask, 4'b1000);
        chk("sb_wdata", bus.mem_req_wdata, 32'hDDDDDDDD);
        chk("sb_req_stall", stall, 1);
        tick;
        chk("sb_done_stall", stall, 0);
        chk("sb_done_valid", bus.mem_req_valid, 0);
        chk("sb_no_load_done", load_done, 0);
        drive(0, OPC_STORE, FNC_SB, 32'h1003, 32'hAABBCCDD);
        tick;
        chk("sb_idle_valid", bus.mem_req_valid, 0);
        chk("sb_idle_stall", stall, 0);
        // LW with ready delayed three cycles, response two cycles after acceptance
        bus.mem_req_ready = 1'b0;
        drive(1, OPC_LOAD, FNC_LW, 32'h2000, 32'h0);
        chk("lw_start_stall", stall, 1);
        tick;
        drive(0, OPC_STORE, FNC_SW, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_valid", bus.mem_req_valid, 1);
            chk("lw_wait_addr", bus.mem_req_addr, 32'h2000);
            chk("lw_wait_we", bus.mem_req_we, 0);
            chk("lw_wait_mask", bus.mem_req_wmask, 0);
            chk("lw_wait_stall", stall, 1);
            tick;
        end
        bus.mem_req_ready = 1'b1;
        #1;
        chk("lw_accept_valid", bus.mem_req_valid, 1);
        tick;
        bus.mem_req_ready = 1'b0;
        chk("lw_resp_valid", bus.mem_req_valid, 0);
        chk("lw_resp_stall", stall, 1);
        tick;
        chk("lw_resp2_stall", stall, 1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h12345678;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("lw_dmem", dmem_out, 32'h12345678);
        chk("lw_done", load_done, 1);
        chk("lw_done_stall", stall, 0);
        chk("lw_lo", lo, 0);
        chk("lw_f3", lf3, FNC_LW);
        tick;
        chk("lw_done_pulse", load_done, 0);
        chk("lw_dmem_hold", dmem_out, 32'h12345678);
        // misaligned LH and SW
        drive(1, OPC_LOAD, FNC_LH, 32'h2001, 32'h0);
        chk("lh_misalign", misalign, 1);
        chk("lh_stall", stall, 0);
        chk("lh_valid", bus.mem_req_valid, 0);
        drive(1, OPC_STORE, FNC_SW, 32'h1002, 32'h0);
        chk("sw_misalign", misalign, 1);
        tick;
        drive(0, OPC_LOAD, FNC_LH, 32'h2001, 32'h0);
        chk("mis_after", misalign, 0);
        chk("mis_no_req", bus.mem_req_valid, 0);
        // SH at upper half
        bus.mem_req_ready = 1'b1;
        drive(1, OPC_STORE, FNC_SH, 32'h4002, 32'h0000BEEF);
        chk("sh_misalign", misalign, 0);
        tick;
        drive(0, OPC_STORE, FNC_SH, 32'h4002, 32'h0);
        chk("sh_wmask", bus.mem_req_wmask, 4'b1100);
        chk("sh_wdata", bus.mem_req_wdata, 32'hBEEFBEEF);
        tick; tick;
        // LBU with an early response while still in REQ
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'hDEADBEEF;
        drive(1, OPC_LOAD, FNC_LBU, 32'h3002, 32'h0);
        tick;
        drive(0, OPC_LOAD, FNC_LBU, 32'h0, 32'h0);
        chk("lbu_req_valid", bus.mem_req_valid, 1);
        tick;
        chk("lbu_early_ignored", bus.mem_req_valid, 1);
        chk("lbu_early_dmem", dmem_out, 32'h12345678);
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h000000A5;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("lbu_dmem", dmem_out, 32'h000000A5);
        chk("lbu_lo", lo, 2);
        chk("lbu_f3", lf3, FNC_LBU);
        chk("lbu_done", load_done, 1);
        tick;
        // reset pulse while waiting in RESP
        bus.mem_req_ready = 1'b1;
        drive(1, OPC_LOAD, FNC_LW, 32'h5004, 32'h0);
        tick;
        drive(0, OPC_LOAD, FNC_LW, 32'h0, 32'h0);
        tick;
        bus.mem_req_ready = 1'b0;
        chk("rr_in_resp", stall, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_dmem", dmem_out, 0);
        chk("rr_stall", stall, 0);
        chk("rr_valid", bus.mem_req_valid, 0);
        chk("rr_lo", lo, 0);
        chk("rr_f3", lf3, 0);
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h00000BAD;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("rr_late_dmem", dmem_out, 0);
        chk("rr_late_done", load_done, 0);
        chk("rr_late_stall", stall, 0);
        bus.mem_req_ready = 1'b1;
        drive(1, OPC_LOAD, FNC_LW, 32'h6008, 32'h0);
        tick;
        drive(0, OPC_LOAD, FNC_LW, 32'h0, 32'h0);
        chk("rr_lw_addr", bus.mem_req_addr, 32'h6008);
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'hCAFEF00D;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("rr_lw_dmem", dmem_out, 32'hCAFEF00D);
        chk("rr_lw_done", load_done, 1);
        tick;
        // back-to-back SW then LW presented during DONE
        drive(1, OPC_STORE, FNC_SW, 32'h7000, 32'h11223344);
        chk("b2b_sw_stall", stall, 1);
        tick;
        chk("b2b_sw_mask", bus.mem_req_wmask, 4'b1111);
        chk("b2b_sw_wdata", bus.mem_req_wdata, 32'h11223344);
        chk("b2b_sw_we", bus.mem_req_we, 1);
        tick;
        drive(1, OPC_LOAD, FNC_LW, 32'h7004, 32'h0);
        chk("b2b_done_stall", stall, 0);
        chk("b2b_done_valid", bus.mem_req_valid, 0);
        tick;
        chk("b2b_lw_start", stall, 1);
        chk("b2b_lw_idle_valid", bus.mem_req_valid, 0);
        tick;
        drive(0, OPC_LOAD, FNC_LW, 32'h0, 32'h0);
        chk("b2b_lw_valid", bus.mem_req_valid, 1);
        chk("b2b_lw_addr", bus.mem_req_addr, 32'h7004);
        chk("b2b_lw_we", bus.mem_req_we, 0);
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h55667788;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("b2b_lw_dmem", dmem_out, 32'h55667788);
        chk("b2b_lw_done", load_done, 1);
        tick;
        chk("b2b_end_valid", bus.mem_req_valid, 0);
        chk("b2b_end_stall", stall, 0);
        chk("req_count", n_req, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_req_unit.md
MEM_REQ_UNIT -- requirements
Module: mem_req_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data path width; only 32 is supported.
REQ-003 The block SHALL have parameter ADDR_W, default 32, giving the byte address width.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port instr_valid_M, input, 1 bit, SHALL indicate that the M stage holds a valid instruction.
REQ-007 Port instr_op_M, input, 7 bits, SHALL carry the M-stage opcode.
REQ-008 Port instr_func3_M, input, 3 bits, SHALL carry the M-stage func3.
REQ-009 Port addr_M, input, ADDR_W bits, SHALL carry the computed byte address.
REQ-010 Port store_data_M, input, DATA_W bits, SHALL carry the rs2 store value.
REQ-011 Port stall_M, output, 1 bit, SHALL hold the pipeline at the M stage.
REQ-012 Port misalign_M, output, 1 bit, SHALL flag a misaligned access.
REQ-013 Port mem_req_valid, output, 1 bit, and port mem_req_ready, input, 1 bit, SHALL form the request handshake.
REQ-014 Ports mem_req_addr (ADDR_W, word-aligned), mem_req_we (1), mem_req_wmask (4) and mem_req_wdata (DATA_W) SHALL be outputs.
REQ-015 Ports mem_resp_valid (1) and mem_resp_data (DATA_W) SHALL be inputs.
REQ-016 Ports DMEM_out (DATA_W), load_addr_lo (2), load_func3 (3) and load_done (1) SHALL be outputs feeding the downstream load-mask stage.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, RESP and DONE.
REQ-018 A start SHALL be recognised in IDLE when instr_valid_M is high, the opcode is LOAD or STORE, and the access is aligned.
- On a start, the FSM SHALL capture the opcode, func3, addr and store data, and go to REQ.
REQ-019 The alignment rules SHALL be:
- Half-word (LH, LHU, SH) misaligned when addr[0]=1.
- Word (LW, SW) misaligned when addr[1:0]!=0.
- Byte accesses always aligned.
REQ-020 A misaligned access in IDLE SHALL pulse misalign_M for that one cycle, issue no request, and not assert stall.
REQ-021 stall_M SHALL be combinational and high when (IDLE and start) or state is REQ or RESP.
- stall_M SHALL be low in DONE.
REQ-022 In REQ, mem_req_valid SHALL be 1, and the address and payload SHALL be held stable until mem_req_ready=1; the request is never retracted.
REQ-023 mem_req_addr SHALL be {addr[ADDR_W-1:2], 2'b00}.
REQ-024 mem_req_we SHALL be 1 for stores only.
REQ-025 Store write mask and data SHALL be:
- SB: wmask = 4'b0001 << addr[1:0]; wdata = four copies of the low byte.
- SH: wmask = 4'b0011 << (2*addr[1]); wdata = two copies of the low half.
- SW: wmask = 4'b1111; wdata = store_data.
- Loads: wmask = 4'b0000.
REQ-026 When the request is accepted in REQ, a store SHALL go to DONE and a load SHALL go to RESP.
REQ-027 In RESP, when mem_resp_valid=1 the block SHALL register mem_resp_data into DMEM_out and go to DONE.
- mem_resp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-028 DONE SHALL last exactly one cycle, then return to IDLE.
- load_done SHALL be 1 in DONE for loads only.
- Inputs SHALL be ignored in DONE, so the advancing instruction is not restarted.
REQ-029 DMEM_out, load_addr_lo and load_func3 SHALL be registered and SHALL hold their last load values until the next load completes.
REQ-030 Minimum latency SHALL be: store, start to DONE in 2 cycles; load, start to DONE in 3 cycles (ready and response each immediate).

Reset
REQ-031 Asserting rst_n low SHALL force IDLE asynchronously at any time and zero all registered outputs.
- Registered outputs: DMEM_out, load_addr_lo, load_func3, load_done and the captured request fields.
- As a result, mem_req_valid=0 and stall_M=0.
REQ-032 Reset mid-transaction SHALL abandon the access, and a late mem_resp_valid after reset SHALL be ignored.

Structure
REQ-033 A shared package mem_pkg SHALL hold the OPC_LOAD/OPC_STORE and FNC_LB/LH/LW/LBU/LHU/SB/SH/SW constants and the FSM state enum.
REQ-034 Store lane alignment SHALL be one combinational sub-module, store_align (inputs func3, addr[1:0], data; outputs wmask, wdata).

Verification
REQ-035 SB, addr 0x1003, data 0xAABBCCDD, ready immediate -> mem_req_addr 0x1000, wmask 4'b1000, wdata 0xDDDDDDDD, stall high 2 cycles, no load_done.
REQ-036 LW, addr 0x2000, ready delayed 3 cycles, response 0x12345678 two cycles later -> stall held throughout, request stable, DMEM_out 0x12345678, load_done one pulse.
REQ-037 LH, addr 0x2001 -> misalign_M one-cycle pulse, mem_req_valid never asserted, stall low.
REQ-038 LBU, addr 0x3002, with mem_resp_valid asserted while still in REQ -> early response ignored; load_addr_lo 2, load_func3 LBU after the real response.
REQ-039 rst_n pulsed low during RESP -> outputs zero, IDLE next, later mem_resp_valid ignored, next LW completes normally.
REQ-040 Back-to-back SW then LW -> the second access starts the cycle after DONE, and neither access is lost nor duplicated.
